// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the 7-segment scan driver
package seg7_pkg;

    localparam int SEG_DP_BIT = 7;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry n is the {g,f,e,d,c,b,a} pattern for nibble n.
    localparam logic [15:0][6:0] SEG_CODE_TBL = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - nibble to active-high segment pattern
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       hex_mode_i,
    input  logic       dp_i,
    output logic [7:0] code_o
);

    always_comb begin
        code_o = {1'b0, SEG_CODE_TBL[nibble_i]};
        if (!hex_mode_i && (nibble_i > 4'd9)) begin
            code_o[6:0] = SEG_BLANK;
        end
        code_o[SEG_DP_BIT] = dp_i;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 7-segment scanner with tear-free frame commit
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 500,
    parameter int HEX_MODE       = 0,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    input  logic                    load,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int DW = idx_width(CLK_DIV);
    localparam int IW = idx_width(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] BLANK_LIM = DW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [7:0]    SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [DW-1:0]         div_q, div_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         sh_val_q, sh_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic                  sh_lz_q, sh_lz_d, act_lz_q, act_lz_d;
    logic                  pend_q, pend_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;

    logic                  slot_end, frame_wrap, suppress, blank;
    logic [VW-1:0]         upper;
    logic [7:0]            code, seg_raw;
    logic [NUM_DIGITS-1:0] onehot;

    assign slot_end   = (div_q == DIV_LAST);
    assign frame_wrap = slot_end && (idx_q == IDX_LAST);
    assign frame_done = frame_wrap;

    // Digit idx is a leading zero when it and every more-significant nibble are zero.
    assign upper    = act_val_q >> {idx_q, 2'b00};
    assign suppress = act_lz_q && (idx_q != '0) && (upper == '0);
    assign blank    = (div_q < BLANK_LIM);
    assign onehot   = NUM_DIGITS'(1) << idx_q;

    seg7_decode u_decode (
        .nibble_i   (upper[3:0]),
        .hex_mode_i (HEX_MODE != 0),
        .dp_i       (act_dp_q[idx_q]),
        .code_o     (code)
    );

    assign seg_raw = suppress ? {code[SEG_DP_BIT], SEG_BLANK} : code;

    always_comb begin
        div_d     = slot_end ? '0 : div_q + 1'b1;
        idx_d     = idx_q;
        sh_val_d  = sh_val_q;
        sh_dp_d   = sh_dp_q;
        sh_lz_d   = sh_lz_q;
        pend_d    = pend_q;
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        act_lz_d  = act_lz_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        // Commit uses the shadow as it stood before this cycle, so a load
        // landing on the wrap cycle waits for the following wrap.
        if (frame_wrap && pend_q) begin
            act_val_d = sh_val_q;
            act_dp_d  = sh_dp_q;
            act_lz_d  = sh_lz_q;
            pend_d    = 1'b0;
        end
        if (load) begin
            sh_val_d = value_in;
            sh_dp_d  = dp_in;
            sh_lz_d  = lz_en;
            pend_d   = 1'b1;
        end
        seg_d = blank ? SEG_OFF : (seg_raw ^ SEG_OFF);
        dig_d = blank ? DIG_OFF : (onehot ^ DIG_OFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            idx_q     <= '0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            sh_lz_q   <= 1'b0;
            pend_q    <= 1'b0;
            act_val_q <= '0;
            act_dp_q  <= '0;
            act_lz_q  <= 1'b0;
            seg_q     <= SEG_OFF;
            dig_q     <= DIG_OFF;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            sh_lz_q   <= sh_lz_d;
            pend_q    <= pend_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            act_lz_q  <= act_lz_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
        end
    end

    assign seg_out = seg_q;
    assign dig_sel = dig_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int CD = 4;
    localparam int BC = 1;
    localparam int FL = N * CD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_en = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  seg_a, seg_h, seg_n;
    logic [3:0]  dig_a, dig_h, dig_n;
    logic        fd_a, fd_h, fd_n;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYC(BC), .HEX_MODE(0),
                       .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) u_dut (
        .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .lz_en(lz_en),
        .load(load), .seg_out(seg_a), .dig_sel(dig_a), .frame_done(fd_a));

    seg7_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYC(BC), .HEX_MODE(1),
                       .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) u_dut_hex (
        .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .lz_en(lz_en),
        .load(load), .seg_out(seg_h), .dig_sel(dig_h), .frame_done(fd_h));

    seg7_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYC(BC), .HEX_MODE(0),
                       .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_dut_neg (
        .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .lz_en(lz_en),
        .load(load), .seg_out(seg_n), .dig_sel(dig_n), .frame_done(fd_n));

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] segtbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Reference state: frame position plus shadow/active copies.
    int          m_cyc = 0;
    bit          m_valid = 1'b0;
    logic [15:0] m_sh_val = '0, m_act_val = '0;
    logic [3:0]  m_sh_dp = '0, m_act_dp = '0;
    logic        m_sh_lz = 1'b0, m_act_lz = 1'b0, m_pend = 1'b0;

    logic [7:0]  cap_a [4];
    logic [7:0]  cap_h [4];
    logic [7:0]  cap_n [4];
    int          en_a [4];

    function automatic logic [7:0] ref_code(input logic [15:0] v, input logic [3:0] dp,
                                            input logic lz, input int idx, input bit hex);
        logic [15:0] up;
        logic [3:0]  nib;
        logic [7:0]  c;
        up  = v >> (4 * idx);
        nib = up[3:0];
        if (lz && idx > 0 && up == 16'h0) c = 8'h00;
        else if (nib < 4'd10 || hex) c = segtbl[nib];
        else c = 8'h00;
        c[7] = dp[idx];
        return c;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        int          pos, idx;
        bit          blank;
        logic [7:0]  e_a, e_h;
        logic [3:0]  e_d;
        pos = m_cyc;
        if (m_valid) begin
            chk("frame_done", {7'b0, fd_a}, {7'b0, pos == FL - 1});
            chk("frame_done_hex", {7'b0, fd_h}, {7'b0, pos == FL - 1});
            chk("frame_done_neg", {7'b0, fd_n}, {7'b0, pos == FL - 1});
        end
        idx   = pos / CD;
        blank = rst || ((pos % CD) < BC);
        e_a = blank ? 8'h00 : ref_code(m_act_val, m_act_dp, m_act_lz, idx, 1'b0);
        e_h = blank ? 8'h00 : ref_code(m_act_val, m_act_dp, m_act_lz, idx, 1'b1);
        e_d = blank ? 4'h0 : 4'(1 << idx);
        if (rst) begin
            m_cyc = 0; m_valid = 1'b1; m_pend = 1'b0;
            m_sh_val = '0; m_sh_dp = '0; m_sh_lz = 1'b0;
            m_act_val = '0; m_act_dp = '0; m_act_lz = 1'b0;
        end else begin
            if (pos == FL - 1 && m_pend) begin
                m_act_val = m_sh_val; m_act_dp = m_sh_dp; m_act_lz = m_sh_lz; m_pend = 1'b0;
            end
            if (load) begin
                m_sh_val = value_in; m_sh_dp = dp_in; m_sh_lz = lz_en; m_pend = 1'b1;
            end
            m_cyc = (pos + 1) % FL;
        end
        @(posedge clk);
        #1;
        chk("seg_out", seg_a, e_a);
        chk("seg_out_hex", seg_h, e_h);
        chk("seg_out_neg", seg_n, ~e_a);
        chk("dig_sel", {4'b0, dig_a}, {4'b0, e_d});
        chk("dig_sel_hex", {4'b0, dig_h}, {4'b0, e_d});
        chk("dig_sel_neg", {4'b0, dig_n}, {4'b0, ~e_d});
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
        value_in = v; dp_in = dp; lz_en = lz; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        for (int k = 0; k < FL && m_cyc != p; k++) tick();
    endtask

    task automatic capture_frame();
        for (int i = 0; i < N; i++) begin
            cap_a[i] = 8'hEE; cap_h[i] = 8'hEE; cap_n[i] = 8'hEE; en_a[i] = 0;
        end
        for (int k = 0; k < FL; k++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (dig_a[i]) begin cap_a[i] = seg_a; en_a[i]++; end
                if (dig_h[i]) cap_h[i] = seg_h;
                if (!dig_n[i]) cap_n[i] = seg_n;
            end
        end
    endtask

    typedef struct packed {
        logic [15:0]     val;
        logic [3:0]      dp;
        logic            lz;
        logic [3:0][7:0] ea;
        logic [3:0][7:0] eh;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n;
        tbl[0] = '{16'h1234, 4'b0000, 1'b0, {8'h06, 8'h5B, 8'h4F, 8'h66}, {8'h06, 8'h5B, 8'h4F, 8'h66}};
        tbl[1] = '{16'hABCD, 4'b0000, 1'b0, {8'h00, 8'h00, 8'h00, 8'h00}, {8'h77, 8'h7C, 8'h39, 8'h5E}};
        tbl[2] = '{16'h0070, 4'b0100, 1'b1, {8'h00, 8'h80, 8'h07, 8'h3F}, {8'h00, 8'h80, 8'h07, 8'h3F}};
        tbl[3] = '{16'h0008, 4'b0000, 1'b0, {8'h3F, 8'h3F, 8'h3F, 8'h7F}, {8'h3F, 8'h3F, 8'h3F, 8'h7F}};
        tbl[4] = '{16'h0000, 4'b1111, 1'b1, {8'h80, 8'h80, 8'h80, 8'hBF}, {8'h80, 8'h80, 8'h80, 8'hBF}};
        tbl[5] = '{16'h0F05, 4'b1010, 1'b1, {8'h80, 8'h00, 8'hBF, 8'h6D}, {8'h80, 8'h71, 8'hBF, 8'h6D}};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n = 0;
        do begin tick(); n++; end while (dig_a == 4'h0 && n < 10);
        chk("first_enable_cycle", 8'(n), 8'(BC + 1));

        for (int e = 0; e < 6; e++) begin
            do_load(tbl[e].val, tbl[e].dp, tbl[e].lz);
            repeat (2 * FL) tick();
            capture_frame();
            for (int i = 0; i < N; i++) begin
                chk("tbl_seg", cap_a[i], tbl[e].ea[i]);
                chk("tbl_seg_hex", cap_h[i], tbl[e].eh[i]);
                chk("tbl_seg_neg", cap_n[i], ~tbl[e].ea[i]);
                chk("tbl_enable_count", 8'(en_a[i]), 8'(CD - BC));
            end
        end

        wait_pos(2);
        do_load(16'h1111, 4'h0, 1'b0);
        do_load(16'h2222, 4'h0, 1'b0);
        wait_pos(FL - 1);
        do_load(16'h3333, 4'h0, 1'b0);
        capture_frame();
        for (int i = 0; i < N; i++) chk("last_wins_frame", cap_a[i], 8'h5B);
        capture_frame();
        for (int i = 0; i < N; i++) chk("wrap_load_frame", cap_a[i], 8'h4F);

        wait_pos(5);
        do_load(16'h5555, 4'h0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_seg_inactive", seg_a, 8'h00);
        chk("rst_dig_neg_inactive", {4'b0, dig_n}, 8'h0F);
        repeat (2 * FL) tick();
        capture_frame();
        for (int i = 0; i < N; i++) chk("rst_discards_pending", cap_a[i], 8'h3F);

        for (int k = 0; k < 800; k++) begin
            rst      = ($urandom_range(0, 199) == 0);
            load     = ($urandom_range(0, 5) == 0);
            value_in = 16'($urandom);
            dp_in    = 4'($urandom);
            lz_en    = 1'($urandom);
            tick();
        end
        rst = 1'b0;
        load = 1'b0;
        repeat (2 * FL) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
